// File: rtl/inst_pkg.sv
// ============================================================================
// Module   : inst_pkg
// Brief    : Shared fetch-side types and defaults (fetch, decode, ROM harness).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package inst_pkg;

    localparam int A_DEFAULT = 8;
    localparam int W_DEFAULT = 9;

    localparam logic [W_DEFAULT-1:0] HALT_WORD = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        NPC_HOLD = 2'd0,
        NPC_INC  = 2'd1,
        NPC_ABS  = 2'd2,
        NPC_REL  = 2'd3
    } next_pc_sel_t;

endpackage

`default_nettype wire

// File: rtl/inst_next_pc.sv
// ============================================================================
// Module   : inst_next_pc
// Brief    : Combinational next-PC mux: hold / +1 / absolute / relative.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_next_pc import inst_pkg::*; #(
    parameter int A = A_DEFAULT
) (
    input  logic [A-1:0] pc,
    input  logic [A-1:0] inst_pc,
    input  logic [A-1:0] branch_target,
    input  logic [1:0]   sel,
    output logic [A-1:0] next_pc
);

    always_comb begin
        next_pc = pc;
        case (sel)
            NPC_INC:  next_pc = pc + A'(1);
            NPC_ABS:  next_pc = branch_target;
            // Unsigned A-bit add wraps exactly like a signed offset would.
            NPC_REL:  next_pc = inst_pc + branch_target;
            default:  next_pc = pc;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/inst_fetch.sv
// ============================================================================
// Module   : inst_fetch
// Brief    : Instruction fetch: PC, fetch FSM, registered Inst/InstPC/InstValid.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch import inst_pkg::*; #(
    parameter int          A        = A_DEFAULT,
    parameter int          W        = W_DEFAULT,
    parameter logic [A-1:0] START_PC = '0
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    output logic [A-1:0] InstAddress,
    input  logic [W-1:0] InstOut,
    input  logic         Stall,
    input  logic         BranchEn,
    input  logic         BranchRel,
    input  logic [A-1:0] BranchTarget,
    output logic [W-1:0] Inst,
    output logic [A-1:0] InstPC,
    output logic         InstValid,
    output logic         Halted
);

    fetch_state_t  r_state;
    logic [A-1:0]  r_pc;
    logic [W-1:0]  r_inst;
    logic [A-1:0]  r_inst_pc;
    logic          r_inst_valid;
    logic          r_halted;

    next_pc_sel_t  w_npc_sel;
    logic [A-1:0]  w_next_pc;
    logic          w_is_halt;

    assign w_is_halt = &InstOut;

    always_comb begin
        w_npc_sel = NPC_HOLD;
        if (r_state == RUN && !Stall) begin
            if (BranchEn)
                w_npc_sel = BranchRel ? NPC_REL : NPC_ABS;
            else if (!w_is_halt)
                w_npc_sel = NPC_INC;
        end
    end

    inst_next_pc #(
        .A (A)
    ) u_next_pc (
        .pc            (r_pc),
        .inst_pc       (r_inst_pc),
        .branch_target (BranchTarget),
        .sel           (w_npc_sel),
        .next_pc       (w_next_pc)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_pc         <= START_PC;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_inst_valid <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_state <= RUN;
                        r_pc    <= START_PC;
                    end
                end
                RUN: begin
                    if (!Stall) begin
                        r_pc <= w_next_pc;
                        // A redirect squashes the word fetched this cycle, halt included.
                        if (BranchEn) begin
                            r_inst_valid <= 1'b0;
                        end else begin
                            r_inst       <= InstOut;
                            r_inst_pc    <= r_pc;
                            r_inst_valid <= 1'b1;
                            if (w_is_halt) begin
                                r_state  <= HALT;
                                r_halted <= 1'b1;
                            end
                        end
                    end
                end
                HALT: begin
                    if (Start) begin
                        r_state      <= RUN;
                        r_pc         <= START_PC;
                        r_halted     <= 1'b0;
                        r_inst_valid <= 1'b0;
                    end else if (!Stall) begin
                        r_inst_valid <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign InstAddress = r_pc;
    assign Inst        = r_inst;
    assign InstPC      = r_inst_pc;
    assign InstValid   = r_inst_valid;
    assign Halted      = r_halted;

endmodule

`default_nettype wire
